// File: rtl/seg_display_scheduler.sv
// Shares a 4-digit seven-segment display between two valid/ready requesters.
// Arbitration is round-robin with a minimum dwell, and the scan has an optional blanking gap between digits.
module seg_display_scheduler #(
    parameter int SCAN_DIV     = 256,
    parameter int BLANK_CYCLES = 16,
    parameter int DWELL        = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic [3:0]  digit_num,
    output logic [3:0]  pos,
    output logic        blank,
    output logic        owner
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0]   SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);

    typedef enum logic {
        ST_SHOW,
        ST_BLANK
    } scan_state_t;

    logic [15:0]        disp_val;
    logic               last_grant;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               dwell_idle;
    logic               xfer0;
    logic               xfer1;

    scan_state_t        state;
    scan_state_t        state_nx;
    logic [1:0]         idx;
    logic [1:0]         idx_nx;
    logic [CNT_W-1:0]   scan_cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [3:0]         pos_nx;
    logic [3:0]         digit_nx;
    logic               blank_nx;

    assign dwell_idle = (dwell_cnt == '0);

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (dwell_idle) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant;
                req1_ready = !last_grant;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign xfer0 = req0_valid && req0_ready;
    assign xfer1 = req1_valid && req1_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            disp_val   <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            dwell_cnt  <= '0;
        end else if (xfer0) begin
            disp_val   <= req0_data;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            dwell_cnt  <= DWELL_LOAD;
        end else if (xfer1) begin
            disp_val   <= req1_data;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            dwell_cnt  <= DWELL_LOAD;
        end else if (!dwell_idle) begin
            dwell_cnt  <= dwell_cnt - DWELL_W'(1);
        end
    end

    // Scan FSM: state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_SHOW;
            idx       <= 2'd0;
            scan_cnt  <= '0;
            pos       <= 4'b1110;
            digit_num <= 4'd0;
            blank     <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            scan_cnt  <= cnt_nx;
            pos       <= pos_nx;
            digit_num <= digit_nx;
            blank     <= blank_nx;
        end
    end

    // Scan FSM: next state. The scan runs free of arbitration.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = scan_cnt + CNT_W'(1);
        case (state)
            ST_SHOW: begin
                if (scan_cnt == SHOW_LAST) begin
                    cnt_nx = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_nx = ST_BLANK;
                    end else begin
                        idx_nx = idx + 2'd1;
                    end
                end
            end
            ST_BLANK: begin
                if (scan_cnt == BLANK_LAST) begin
                    cnt_nx   = '0;
                    state_nx = ST_SHOW;
                    idx_nx   = idx + 2'd1;
                end
            end
            default: begin
                state_nx = ST_SHOW;
                cnt_nx   = '0;
            end
        endcase
    end

    // Scan FSM: outputs. The digit is snapshotted on entry to SHOW and held for the phase.
    always_comb begin
        pos_nx   = pos;
        digit_nx = digit_num;
        blank_nx = blank;
        if (state == ST_SHOW && state_nx == ST_BLANK) begin
            pos_nx   = 4'b1111;
            blank_nx = 1'b1;
        end else if (state_nx == ST_SHOW && idx_nx != idx) begin
            pos_nx   = ~(4'b0001 << idx_nx);
            digit_nx = disp_val[idx_nx*4 +: 4];
            blank_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: one instance with blanking and dwell 8, one with no blanking and dwell 1.
// A table of per-cycle vectors plus hand-written sequences for the reset and scan corner cases.
module tb_seg_display_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic        req1_valid;
    logic [15:0] req0_data;
    logic [15:0] req1_data;

    logic        a_ready0, a_ready1, a_blank, a_owner;
    logic [3:0]  a_digit, a_pos;
    logic        b_ready0, b_ready1, b_blank, b_owner;
    logic [3:0]  b_digit, b_pos;

    int          checks   = 0;
    int          failures = 0;
    int unsigned k        = 0;

    typedef struct packed {
        logic        idx;
        logic [15:0] data;
    } xfer_t;
    xfer_t sb_q[$];

    typedef struct {
        logic        v0;
        logic [15:0] d0;
        logic        v1;
        logic [15:0] d1;
        logic        er0;
        logic        er1;
        logic        eown;
    } vec_t;
    vec_t vecs[25];

    always #5 clk = ~clk;

    seg_display_scheduler #(.SCAN_DIV(4), .BLANK_CYCLES(2), .DWELL(8)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(a_ready0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(a_ready1),
        .digit_num(a_digit), .pos(a_pos), .blank(a_blank), .owner(a_owner)
    );

    seg_display_scheduler #(.SCAN_DIV(3), .BLANK_CYCLES(0), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_ready0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_ready1),
        .digit_num(b_digit), .pos(b_pos), .blank(b_blank), .owner(b_owner)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rising edges since the last reset release; the scan position follows from it alone.
    always @(posedge clk or negedge rst) begin
        if (!rst) k <= 0;
        else      k <= k + 1;
    end

    int unsigned pa, pb;
    logic [3:0]  ea, eb;
    always @(negedge clk) begin
        pa = k % 24;
        if ((pa % 6) < 4) ea = ~(4'b0001 << (pa / 6));
        else              ea = 4'b1111;
        check("scan_a_pos", 32'(a_pos), 32'(ea));
        check("scan_a_blank", 32'(a_blank), 32'(ea == 4'b1111));
        pb = k % 12;
        eb = ~(4'b0001 << (pb / 3));
        check("scan_b_pos", 32'(b_pos), 32'(eb));
        check("scan_b_blank", 32'(b_blank), 32'(0));
    end

    // Scoreboard: transfers on dut_a are matched against the queue in order.
    xfer_t got, exp_x;
    always @(posedge clk) begin
        if (rst === 1'b1 && ((req0_valid && a_ready0) || (req1_valid && a_ready1))) begin
            check("ready_onehot", 32'(a_ready0 & a_ready1), 32'(0));
            got.idx  = (req1_valid && a_ready1);
            got.data = got.idx ? req1_data : req0_data;
            check("sb_expected_xfer", 32'(sb_q.size() != 0), 32'(1));
            if (sb_q.size() != 0) begin
                exp_x = sb_q.pop_front();
                check("sb_idx", 32'(got.idx), 32'(exp_x.idx));
                check("sb_data", 32'(got.data), 32'(exp_x.data));
            end
        end
    end

    task automatic expect_digit(input int idx, input logic [3:0] exp, input string name);
        int unsigned k0;
        bit          found;
        k0    = k;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (k > k0 && (k % 24) == idx * 6) found = 1'b1;
        end
        check({name, "_reached"}, 32'(found), 32'(1));
        if (found) check(name, 32'(a_digit), 32'(exp));
    endtask

    initial begin
        bit found;

        for (int i = 0; i < 25; i++) begin
            vecs[i].v0   = (i <= 8);
            vecs[i].d0   = 16'h1111;
            vecs[i].v1   = 1'b1;
            vecs[i].d1   = (i <= 8) ? 16'h2222 : (i <= 16) ? 16'h3333 : 16'h4444;
            vecs[i].er0  = (i == 0);
            vecs[i].er1  = (i == 8 || i == 16 || i == 24);
            vecs[i].eown = (i >= 9);
        end

        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;

        // Reset values and a free-running scan with no requests.
        repeat (2) @(negedge clk);
        #1;
        check("rst_pos", 32'(a_pos), 32'(4'b1110));
        check("rst_digit", 32'(a_digit), 32'(0));
        check("rst_blank", 32'(a_blank), 32'(0));
        check("rst_owner", 32'(a_owner), 32'(0));
        check("rst_ready0", 32'(a_ready0), 32'(0));
        check("rst_ready1", 32'(a_ready1), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            check("idle_digit", 32'(a_digit), 32'(0));
        end

        // Single request and nibble ordering on the display.
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 16'hA5C3;
        #1;
        check("single_ready0", 32'(a_ready0), 32'(1));
        check("single_ready1", 32'(a_ready1), 32'(0));
        sb_q.push_back('{idx: 1'b0, data: 16'hA5C3});
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("single_owner", 32'(a_owner), 32'(0));
        expect_digit(0, 4'h3, "digit0_a5c3");
        expect_digit(1, 4'hC, "digit1_a5c3");
        expect_digit(2, 4'h5, "digit2_a5c3");
        expect_digit(3, 4'hA, "digit3_a5c3");

        // Contention after reset, then a continuously valid requester paced by the dwell.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            req0_valid = vecs[i].v0;
            req0_data  = vecs[i].d0;
            req1_valid = vecs[i].v1;
            req1_data  = vecs[i].d1;
            #1;
            check($sformatf("vec%0d_ready0", i), 32'(a_ready0), 32'(vecs[i].er0));
            check($sformatf("vec%0d_ready1", i), 32'(a_ready1), 32'(vecs[i].er1));
            check($sformatf("vec%0d_owner", i), 32'(a_owner), 32'(vecs[i].eown));
            if (vecs[i].er0) sb_q.push_back('{idx: 1'b0, data: vecs[i].d0});
            if (vecs[i].er1) sb_q.push_back('{idx: 1'b1, data: vecs[i].d1});
            if (!vecs[i].v0 && vecs[i].v1)
                check($sformatf("vec%0d_b_ready1", i), 32'(b_ready1), 32'(1));
        end

        // Reset asserted mid-blank and mid-dwell with a requester pending.
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("last_owner", 32'(a_owner), 32'(1));
        found = 1'b0;
        for (int n = 0; n < 6 && !found; n++) begin
            if (a_blank) found = 1'b1;
            else         @(negedge clk);
        end
        check("mid_blank_found", 32'(found), 32'(1));
        req1_data  = 16'h5555;
        req1_valid = 1'b1;
        #1;
        check("ready_during_dwell", 32'(a_ready1), 32'(0));
        #1;
        rst = 1'b0;
        #1;
        check("midrst_pos", 32'(a_pos), 32'(4'b1110));
        check("midrst_blank", 32'(a_blank), 32'(0));
        check("midrst_digit", 32'(a_digit), 32'(0));
        check("midrst_owner", 32'(a_owner), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_release", 32'(a_ready1), 32'(1));
        sb_q.push_back('{idx: 1'b1, data: 16'h5555});
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("owner_after_release", 32'(a_owner), 32'(1));
        expect_digit(0, 4'h5, "digit0_5555");
        expect_digit(3, 4'h5, "digit3_5555");

        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
